// File: rtl/xc_sha3_addr_seq.sv
// Keccak state address sequencer: sweeps x/y indices through an attached xc_sha3
// index unit and streams base-relative byte addresses. Optional abort: XC_SHA3_SEQ_ABORT_EN.
module xc_sha3_addr_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic [31:0] base,
  input  logic [1:0]  shamt,
`ifdef XC_SHA3_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic [31:0] sha3_rs1,
  output logic [31:0] sha3_rs2,
  output logic [1:0]  sha3_shamt,
  output logic        sha3_f_xy,
  output logic        sha3_f_x1,
  output logic        sha3_f_x2,
  output logic        sha3_f_x4,
  output logic        sha3_f_yx,
  input  logic [31:0] sha3_result,
  output logic        addr_valid,
  input  logic        addr_ready,
  output logic [31:0] addr,
  output logic [4:0]  addr_idx,
  output logic        addr_last,
  output logic        done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;
  typedef enum logic [2:0] {
    MODE_XY = 3'd0, MODE_X1 = 3'd1, MODE_X2 = 3'd2, MODE_X4 = 3'd3, MODE_YX = 3'd4
  } mode_e;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [31:0] base_q, base_d;
  logic [1:0]  shamt_q, shamt_d;
  logic [2:0]  x_q, x_d, y_q, y_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic [4:0]  len_m1;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_XY;
      base_q  <= '0;
      shamt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      shamt_q <= shamt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    shamt_d = shamt_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
    len_m1  = (mode_q == MODE_XY || mode_q == MODE_YX) ? 5'd24 : 5'd4;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (mode <= 3'd4)) begin
          state_d = ST_RUN;
          mode_d  = mode_e'(mode);
          base_d  = base;
          shamt_d = shamt;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // The output register doubles as a one-deep skid: reload whenever it is empty or being taken.
        if (!valid_q || addr_ready) begin
          addr_d  = base_q + sha3_result;
          idx_d   = cnt_q;
          last_d  = (cnt_q == len_m1);
          valid_d = 1'b1;
          cnt_d   = cnt_q + 5'd1;
          if (x_q == 3'd4) begin
            x_d = '0;
            y_d = y_q + 3'd1;
          end else begin
            x_d = x_q + 3'd1;
          end
          if (cnt_q == len_m1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (valid_q && addr_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef XC_SHA3_SEQ_ABORT_EN
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
`endif
  end

  assign busy       = (state_q != ST_IDLE);
  assign sha3_rs1   = {29'd0, x_q};
  assign sha3_rs2   = {29'd0, y_q};
  assign sha3_shamt = shamt_q;
  assign sha3_f_xy  = (state_q == ST_RUN) && (mode_q == MODE_XY);
  assign sha3_f_x1  = (state_q == ST_RUN) && (mode_q == MODE_X1);
  assign sha3_f_x2  = (state_q == ST_RUN) && (mode_q == MODE_X2);
  assign sha3_f_x4  = (state_q == ST_RUN) && (mode_q == MODE_X4);
  assign sha3_f_yx  = (state_q == ST_RUN) && (mode_q == MODE_YX);
  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign addr_idx   = idx_q;
  assign addr_last  = last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_xc_sha3_addr_seq.sv
// Bench for xc_sha3_addr_seq: attached xc_sha3 index model, sweep-level reference model,
// per-cycle comparison plus directed sweeps with literal expectations.
module tb_xc_sha3_addr_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        start = 1'b0;
  logic [2:0]  mode = '0;
  logic [31:0] base = '0;
  logic [1:0]  shamt = '0;
  logic        addr_ready = 1'b1;
`ifdef XC_SHA3_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        busy, addr_valid, addr_last, done;
  logic [31:0] sha3_rs1, sha3_rs2, sha3_result, addr;
  logic [1:0]  sha3_shamt;
  logic        sha3_f_xy, sha3_f_x1, sha3_f_x2, sha3_f_x4, sha3_f_yx;
  logic [4:0]  addr_idx;

  int n_checks = 0;
  int n_err = 0;

  always #5 g_clk = ~g_clk;

  xc_sha3_addr_seq dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .start(start), .mode(mode), .base(base), .shamt(shamt),
`ifdef XC_SHA3_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .sha3_rs1(sha3_rs1), .sha3_rs2(sha3_rs2), .sha3_shamt(sha3_shamt),
    .sha3_f_xy(sha3_f_xy), .sha3_f_x1(sha3_f_x1), .sha3_f_x2(sha3_f_x2),
    .sha3_f_x4(sha3_f_x4), .sha3_f_yx(sha3_f_yx), .sha3_result(sha3_result),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr), .addr_idx(addr_idx),
    .addr_last(addr_last), .done(done)
  );

  // Keccak lane index functions of the downstream xc_sha3 unit.
  function automatic logic [31:0] idx_fn(input int m, input int x, input int y, input int sh);
    int r;
    case (m)
      0: r = (x % 5) + 5 * (y % 5);
      1: r = ((x + 1) % 5) + 5 * (y % 5);
      2: r = ((x + 2) % 5) + 5 * (y % 5);
      3: r = ((x + 4) % 5) + 5 * (y % 5);
      4: r = (y % 5) + 5 * ((2 * x + 3 * y) % 5);
      default: r = 0;
    endcase
    return 32'(r) << sh;
  endfunction

  always_comb begin
    sha3_result = '0;
    if (sha3_f_xy) sha3_result = idx_fn(0, int'(sha3_rs1[2:0]), int'(sha3_rs2[2:0]), int'(sha3_shamt));
    if (sha3_f_x1) sha3_result = idx_fn(1, int'(sha3_rs1[2:0]), int'(sha3_rs2[2:0]), int'(sha3_shamt));
    if (sha3_f_x2) sha3_result = idx_fn(2, int'(sha3_rs1[2:0]), int'(sha3_rs2[2:0]), int'(sha3_shamt));
    if (sha3_f_x4) sha3_result = idx_fn(3, int'(sha3_rs1[2:0]), int'(sha3_rs2[2:0]), int'(sha3_shamt));
    if (sha3_f_yx) sha3_result = idx_fn(4, int'(sha3_rs1[2:0]), int'(sha3_rs2[2:0]), int'(sha3_shamt));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: a sweep is a list of element numbers 0..len-1; element i sits at
  // x=i%5, y=i/5. The output slot refills whenever it is empty or being consumed.
  bit          m_active = 0, m_valid = 0, m_done = 0, m_last = 0;
  int          m_mode = 0, m_len = 0, m_next = 0, m_idx = 0;
  logic [31:0] m_base = '0, m_addr = '0;
  logic [1:0]  m_shamt = '0;

  initial forever begin
    @(posedge g_clk or negedge g_resetn);
    if (!g_resetn) begin
      m_active = 0; m_valid = 0; m_done = 0; m_shamt = '0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start && mode <= 3'd4) begin
          m_active = 1; m_mode = int'(mode); m_base = base; m_shamt = shamt; m_next = 0;
          m_len = (m_mode == 0 || m_mode == 4) ? 25 : 5;
        end
`ifdef XC_SHA3_SEQ_ABORT_EN
      end else if (abort) begin
        m_active = 0; m_valid = 0;
`endif
      end else if (m_valid && addr_ready && m_next == m_len) begin
        m_done = 1; m_valid = 0; m_active = 0;
      end else if ((!m_valid || addr_ready) && m_next < m_len) begin
        m_addr  = m_base + idx_fn(m_mode, m_next % 5, m_next / 5, int'(m_shamt));
        m_idx   = m_next;
        m_last  = (m_next == m_len - 1);
        m_valid = 1;
        m_next++;
      end
    end
  end

  // Handshake capture and per-cycle comparison against the model.
  logic [31:0] cap_addr [32];
  int          cap_idx  [32];
  bit          cap_last [32];
  int          hs_cnt = 0, n_done = 0, n_lasts = 0;
  bit          p_valid = 0, p_ready = 0;
  logic [31:0] p_addr = '0;
  logic [4:0]  p_idx = '0;

  initial forever begin
    @(negedge g_clk);
    chk("busy", 32'(busy), 32'(m_active));
    chk("addr_valid", 32'(addr_valid), 32'(m_valid));
    chk("done", 32'(done), 32'(m_done));
    chk("sha3_shamt", 32'(sha3_shamt), 32'(m_shamt));
    chk("rs_upper", sha3_rs1[31:3] | sha3_rs2[31:3], 32'd0);
    chk("selects", 32'({sha3_f_yx, sha3_f_x4, sha3_f_x2, sha3_f_x1, sha3_f_xy}),
        (m_active && m_next < m_len) ? (32'd1 << m_mode) : 32'd0);
    if (m_valid) begin
      chk("addr", addr, m_addr);
      chk("addr_idx", 32'(addr_idx), 32'(m_idx));
      chk("addr_last", 32'(addr_last), 32'(m_last));
    end
    if (p_valid && !p_ready && m_valid)
      chk("stall_hold", {addr[26:0], addr_idx}, {p_addr[26:0], p_idx});
    if (done) n_done++;
    if (addr_valid && addr_ready && hs_cnt < 32) begin
      cap_addr[hs_cnt] = addr; cap_idx[hs_cnt] = int'(addr_idx); cap_last[hs_cnt] = addr_last;
      if (addr_last) n_lasts++;
      hs_cnt++;
    end
    p_valid = addr_valid; p_ready = addr_ready; p_addr = addr; p_idx = addr_idx;
  end

  task automatic cyc();
    @(posedge g_clk); #2;
  endtask

  // Starts a sweep and returns the cycle (counted from the accepting edge) that showed done.
  task automatic run_sweep(input logic [2:0] md, input logic [31:0] b, input logic [1:0] sh,
                           input bit stall, input bit inject_start, output int k);
    hs_cnt = 0; n_lasts = 0;
    start = 1'b1; mode = md; base = b; shamt = sh;
    cyc();
    start = 1'b0;
    for (k = 0; k < 400; k++) begin
      if (stall) addr_ready = ($urandom_range(0, 3) != 0);
      if (inject_start) begin
        start = (k == 8); mode = 3'd1;
      end
      @(negedge g_clk);
      if (done) break;
      cyc();
    end
    if (k >= 400) chk("sweep_timeout", 32'(k), 32'd0);
    addr_ready = 1'b1; start = 1'b0;
    cyc();
  endtask

  initial begin
    int k, d0;
    g_resetn = 1'b0;
    repeat (3) cyc();
    chk("rst_addr", addr, 32'd0);
    chk("rst_idx", 32'(addr_idx), 32'd0);
    chk("rst_last", 32'(addr_last), 32'd0);
    chk("rst_rs", sha3_rs1 | sha3_rs2, 32'd0);
    g_resetn = 1'b1;
    cyc();

    // xy sweep, continuous ready
    run_sweep(3'd0, 32'h1000, 2'd3, 0, 0, k);
    chk("xy_done_cycle", 32'(k), 32'd26);
    chk("xy_count", 32'(hs_cnt), 32'd25);
    chk("xy_first", cap_addr[0], 32'h1000);
    chk("xy_idx7", cap_addr[7], 32'h1038);
    chk("xy_idx24", cap_addr[24], 32'h1000 + (32'd24 << 3));
    chk("xy_last24", 32'(cap_last[24]), 32'd1);
    chk("xy_nlast", 32'(n_lasts), 32'd1);
    for (int i = 0; i < 25; i++) chk("xy_order", 32'(cap_idx[i]), 32'(i));

    // x1 sweep
    run_sweep(3'd1, 32'h0, 2'd0, 0, 0, k);
    chk("x1_done_cycle", 32'(k), 32'd6);
    chk("x1_a0", cap_addr[0], 32'd1);
    chk("x1_a1", cap_addr[1], 32'd2);
    chk("x1_a2", cap_addr[2], 32'd3);
    chk("x1_a3", cap_addr[3], 32'd4);
    chk("x1_a4", cap_addr[4], 32'd0);
    chk("x1_last4", 32'(cap_last[4]), 32'd1);
    chk("x1_last3", 32'(cap_last[3]), 32'd0);

    // x4 sweep with wrapping base
    run_sweep(3'd3, 32'hFFFF_FFF8, 2'd3, 0, 0, k);
    chk("x4_wrap", cap_addr[0], 32'h0000_0018);
    chk("x4_count", 32'(hs_cnt), 32'd5);

    // reserved mode in IDLE
    start = 1'b1; mode = 3'd6;
    cyc();
    start = 1'b0;
    @(negedge g_clk);
    chk("rsvd_busy", 32'(busy), 32'd0);
    cyc();

    // xy with random stalls and a start while busy
    d0 = n_done;
    run_sweep(3'd0, 32'h2000, 2'd2, 1, 1, k);
    chk("stall_count", 32'(hs_cnt), 32'd25);
    chk("stall_ndone", 32'(n_done - d0), 32'd1);
    for (int i = 0; i < 25; i++) chk("stall_order", 32'(cap_idx[i]), 32'(i));

    // yx sweep
    run_sweep(3'd4, 32'h400, 2'd1, 0, 0, k);
    chk("yx_done_cycle", 32'(k), 32'd26);
    chk("yx_count", 32'(hs_cnt), 32'd25);

    // reset mid-sweep at element 10, then a clean x2 sweep
    hs_cnt = 0;
    start = 1'b1; mode = 3'd0; base = 32'h3000; shamt = 2'd0;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 60 && hs_cnt < 10; i++) cyc();
    d0 = n_done;
    g_resetn = 1'b0;
    @(negedge g_clk);
    chk("rst_mid_valid", 32'(addr_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    cyc();
    g_resetn = 1'b1;
    repeat (5) cyc();
    chk("rst_mid_nodone", 32'(n_done - d0), 32'd0);
    run_sweep(3'd2, 32'h200, 2'd1, 0, 0, k);
    chk("x2_done_cycle", 32'(k), 32'd6);
    chk("x2_a0", cap_addr[0], 32'h204);
    chk("x2_a2", cap_addr[2], 32'h208);
    chk("x2_a3", cap_addr[3], 32'h200);
    chk("x2_a4", cap_addr[4], 32'h202);

`ifdef XC_SHA3_SEQ_ABORT_EN
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    hs_cnt = 0;
    start = 1'b1; mode = 3'd0; base = 32'h0; shamt = 2'd0;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 60 && hs_cnt < 10; i++) cyc();
    d0 = n_done;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    @(negedge g_clk);
    chk("abort_valid", 32'(addr_valid), 32'd0);
    repeat (4) cyc();
    chk("abort_nodone", 32'(n_done - d0), 32'd0);
    run_sweep(3'd1, 32'h0, 2'd0, 0, 0, k);
    chk("abort_clean", 32'(hs_cnt), 32'd5);
`endif

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/xc_sha3_addr_seq.md
XC_SHA3_ADDR_SEQ -- requirements
Module: xc_sha3_addr_seq

Interface
REQ-001 g_clk  in  1  single clock; all state updates on rising edge.
REQ-002 g_resetn  in  1  asynchronous active-low reset.
REQ-003 start  in  1  pulse; requests a sweep, sampled only in IDLE.
REQ-004 mode  in  3  sweep type: 0=xy, 1=x1, 2=x2, 3=x4, 4=yx; 5-7 reserved.
REQ-005 base  in  32  byte base address of the Keccak state buffer.
REQ-006 shamt  in  2  post-shift amount.
REQ-007 busy  out  1  high while not IDLE.
REQ-008 sha3_rs1, sha3_rs2  out  32 each  index operands to the downstream xc_sha3 instance; bits [31:3] are zero.
REQ-009 sha3_shamt  out  2  latched shamt.
REQ-010 sha3_f_xy, sha3_f_x1, sha3_f_x2, sha3_f_x4, sha3_f_yx  out  1 each  one-hot function select; all zero in IDLE.
REQ-011 sha3_result  in  32  combinational index result returned by xc_sha3.
REQ-012 addr_valid  out  1; addr_ready  in  1; addr  out  32; addr_idx  out  5; addr_last  out  1  output address stream.
REQ-013 done  out  1  single-cycle pulse at sweep completion.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DRAIN.
REQ-015 IDLE->RUN on start with a valid mode; the block SHALL latch mode, base and shamt and clear the x, y and count registers in the same cycle.
REQ-016 In IDLE, a start with a reserved mode SHALL be ignored; start SHALL be ignored in every non-IDLE state.
REQ-017 Sweep length: xy and yx are 25 elements (x inner 0..4, y outer 0..4); x1, x2 and x4 are 5 elements (x 0..4, y=0).
REQ-018 sha3_rs1 SHALL equal {29'b0,x} and sha3_rs2 SHALL equal {29'b0,y}, both driven from registers; the selects SHALL be decoded from the latched mode and be active only in RUN.
REQ-019 The output register is loadable in RUN when addr_valid=0 or addr_ready=1; on load: addr = base + sha3_result (32-bit modulo wrap), addr_idx = count, addr_last = (count == length-1), addr_valid = 1.
REQ-020 On each load the block SHALL advance x, y and count; on the last load it SHALL move to DRAIN.
REQ-021 DRAIN: once the last element is accepted (valid & ready), the block SHALL pulse done for one cycle, clear addr_valid and return to IDLE.
REQ-022 While addr_valid=1 and addr_ready=0, the addr, addr_idx and addr_last outputs SHALL hold stable.
REQ-023 Throughput SHALL be one element per cycle under continuous ready; the first addr_valid SHALL rise the cycle after start is accepted.
REQ-024 A full 25-element sweep with ready held high SHALL take 25 valid cycles, with done asserted in cycle 26 after start.

Reset
REQ-025 Reset SHALL force: state=IDLE, x=y=count=0, busy=0, addr_valid=0, addr=0, addr_idx=0, addr_last=0, done=0, all selects=0, sha3_shamt=0.
REQ-026 Reset asserted mid-sweep SHALL discard the sweep immediately; no done pulse SHALL be produced.

Configuration
REQ-027 Macro XC_SHA3_SEQ_ABORT_EN: when defined, the block SHALL add an input abort (1 bit) that, in RUN or DRAIN, returns the block to IDLE on the next edge, clears addr_valid and suppresses done; abort in IDLE SHALL have no effect.
REQ-028 Without XC_SHA3_SEQ_ABORT_EN, the port SHALL NOT exist and a sweep SHALL always run to completion.

Verification
REQ-029 mode=0 (xy), base=0x1000, shamt=3, ready=1, bench xc_sha3 attached -> 25 addresses in idx order 0..24; idx 7 (x=2, y=1) gives 0x1000+((2+5)<<3)=0x1038; last only on idx 24; done in cycle 26.
REQ-030 mode=1 (x1), base=0, shamt=0 -> 5 addresses 1,2,3,4,0; addr_last on the 5th.
REQ-031 Random ready deasserts during an xy sweep -> outputs stable while stalled; no element lost or duplicated.
REQ-032 start while busy, and start with mode=6 in IDLE -> both ignored; busy stays at its prior value.
REQ-033 base=0xFFFFFFF8, mode=3, shamt=3 -> first addr=0xFFFFFFF8+(4<<3)=0x00000018 (wraps).
REQ-034 g_resetn low at element 10, and (if ABORT_EN) abort at element 10 -> addr_valid=0 next cycle, no done, and the next start runs a clean sweep.
